mem_arbiter: RTL and testbench

Two-master arbiter that shares one single-ported 16-bit memory between requesters, typically the instruction-fetch side and the load/store side of the multicycle CPU, or two CPU cores on a common data memory. Each master issues a level request with address, write data and direction. The arbiter picks one master by round-robin, drives the memory for a fixed latency, returns read data and pulses a one-cycle acknowledge. Only one transaction is in flight at a time.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for one single-ported memory
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] a0,
    input  logic [AW-1:0] a1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic [AW-1:0] ma,
    output logic [DW-1:0] mwd,
    output logic          mrw,
    input  logic [DW-1:0] mrd,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdat_q, wdat_d;
    logic          rw_q, rw_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [DW-1:0] rd0_q, rd0_d;
    logic [DW-1:0] rd1_q, rd1_d;
    logic          grant;

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rw_q    <= 1'b1;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rw_q    <= rw_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rw_d    = rw_q;
        owner_d = owner_q;
        last_d  = last_q;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
        // On a tie the master that was not served last wins.
        grant   = (req0 && req1) ? ~last_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    addr_d  = grant ? a1 : a0;
                    wdat_d  = grant ? wd1 : wd0;
                    rw_d    = grant ? rw1 : rw0;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (rw_q) begin
                        if (owner_q) rd1_d = mrd;
                        else         rd0_d = mrd;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack0  = (state_q == DONE) && !owner_q;
    assign ack1  = (state_q == DONE) && owner_q;
    assign rd0   = rd0_q;
    assign rd1   = rd1_q;
    assign ma    = addr_q;
    assign mwd   = wdat_q;
    assign mrw   = !((state_q == ACCESS) && !rw_q);
    assign busy  = (state_q != IDLE);
    assign owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT 1 and 3
module tb_mem_arbiter;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge ck) cyc++;

    typedef struct {
        bit          port;
        logic [15:0] rd;
        int          cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    logic        s1_req0, s1_req1, s1_rw0, s1_rw1, s1_ack0, s1_ack1, s1_mrw, s1_busy, s1_owner;
    logic [15:0] s1_a0, s1_a1, s1_wd0, s1_wd1, s1_rd0, s1_rd1, s1_ma, s1_mwd, s1_mrd;
    logic        s3_req0, s3_req1, s3_rw0, s3_rw1, s3_ack0, s3_ack1, s3_mrw, s3_busy, s3_owner;
    logic [15:0] s3_a0, s3_a1, s3_wd0, s3_wd1, s3_rd0, s3_rd1, s3_ma, s3_mwd, s3_mrd;

    logic [15:0] mem1 [0:65535];
    logic [15:0] mem3 [0:65535];

    assign s1_mrd = mem1[s1_ma];
    assign s3_mrd = mem3[s3_ma];
    always @(posedge ck) if (s1_mrw == 1'b0) mem1[s1_ma] <= s1_mwd;
    always @(posedge ck) if (s3_mrw == 1'b0) mem3[s3_ma] <= s3_mwd;

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u1 (
        .ck(ck), .rst(rst),
        .req0(s1_req0), .req1(s1_req1), .rw0(s1_rw0), .rw1(s1_rw1),
        .a0(s1_a0), .a1(s1_a1), .wd0(s1_wd0), .wd1(s1_wd1),
        .ack0(s1_ack0), .ack1(s1_ack1), .rd0(s1_rd0), .rd1(s1_rd1),
        .ma(s1_ma), .mwd(s1_mwd), .mrw(s1_mrw), .mrd(s1_mrd),
        .busy(s1_busy), .owner(s1_owner)
    );

    mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u3 (
        .ck(ck), .rst(rst),
        .req0(s3_req0), .req1(s3_req1), .rw0(s3_rw0), .rw1(s3_rw1),
        .a0(s3_a0), .a1(s3_a1), .wd0(s3_wd0), .wd1(s3_wd1),
        .ack0(s3_ack0), .ack1(s3_ack1), .rd0(s3_rd0), .rd1(s3_rd1),
        .ma(s3_ma), .mwd(s3_mwd), .mrw(s3_mrw), .mrd(s3_mrd),
        .busy(s3_busy), .owner(s3_owner)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic ack_monitor(input string tag, input logic a0, input logic a1,
                               input logic [15:0] r0, input logic [15:0] r1,
                               inout exp_t q[$]);
        exp_t e;
        if (a0 === 1'b1 || a1 === 1'b1) begin
            if (a0 === 1'b1 && a1 === 1'b1) chk({tag, "_dual_ack"}, 32'd1, 32'd0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_ack at cycle %0d: ack0=%b ack1=%b, expected none", tag, cyc, a0, a1);
            end else begin
                e = q.pop_front();
                chk({tag, "_ack_port"}, {31'd0, a1}, {31'd0, e.port});
                chk({tag, "_ack_cycle"}, cyc, e.cyc);
                chk({tag, "_rd"}, {16'd0, (e.port ? r1 : r0)}, {16'd0, e.rd});
            end
        end
    endtask

    always @(negedge ck) ack_monitor("u1", s1_ack0, s1_ack1, s1_rd0, s1_rd1, q1);
    always @(negedge ck) ack_monitor("u3", s3_ack0, s3_ack1, s3_rd0, s3_rd1, q3);

    // One LAT=1 transaction by master m: request held until the cycle after ack.
    task automatic txn1(input bit m, input bit rw, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp_rd);
        int c0;
        if (m) begin s1_req1 = 1'b1; s1_rw1 = rw; s1_a1 = a; s1_wd1 = wd; end
        else   begin s1_req0 = 1'b1; s1_rw0 = rw; s1_a0 = a; s1_wd0 = wd; end
        c0 = cyc;
        q1.push_back('{m, exp_rd, c0 + 2});
        for (int k = 0; k < 3; k++) begin
            @(negedge ck);
            chk("u1_mrw", {31'd0, s1_mrw}, {31'd0, !(k == 1 && !rw)});
            if (k == 1) chk("u1_ma", {16'd0, s1_ma}, {16'd0, a});
            step();
        end
        if (m) s1_req1 = 1'b0;
        else   s1_req0 = 1'b0;
    endtask

    initial begin
        int  c0;
        bit  exp_own;
        mem1[0] = 16'h0000;
        mem3[0] = 16'h0000;
        mem1[16'h0010] = 16'h1234;
        mem3[16'h0030] = 16'hA5A5;
        mem3[16'h0040] = 16'h5555;

        rst = 1'b1;
        {s1_req0, s1_req1, s1_rw0, s1_rw1} = 4'($urandom);
        {s3_req0, s3_req1, s3_rw0, s3_rw1} = 4'($urandom);
        s1_a0 = 16'($urandom); s1_a1 = 16'($urandom); s1_wd0 = 16'($urandom); s1_wd1 = 16'($urandom);
        s3_a0 = 16'($urandom); s3_a1 = 16'($urandom); s3_wd0 = 16'($urandom); s3_wd1 = 16'($urandom);
        step();
        step();
        @(negedge ck);
        chk("rst_acks", {28'd0, s1_ack0, s1_ack1, s3_ack0, s3_ack1}, 32'd0);
        chk("rst_rd_u1", {s1_rd0, s1_rd1}, 32'd0);
        chk("rst_rd_u3", {s3_rd0, s3_rd1}, 32'd0);
        chk("rst_ma_mwd_u1", {s1_ma, s1_mwd}, 32'd0);
        chk("rst_ma_mwd_u3", {s3_ma, s3_mwd}, 32'd0);
        chk("rst_mrw_busy_owner", {26'd0, s1_mrw, s1_busy, s1_owner, s3_mrw, s3_busy, s3_owner},
            {26'd0, 6'b100100});
        rst = 1'b0;
        {s1_req0, s1_req1, s3_req0, s3_req1} = 4'b0000;
        step();

        txn1(1'b0, 1'b1, 16'h0010, 16'h0000, 16'h1234);
        txn1(1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h0000);
        txn1(1'b1, 1'b1, 16'h0020, 16'h0000, 16'hBEEF);
        chk("mem_write_commit", {16'd0, mem1[16'h0020]}, 32'h0000BEEF);

        // Contention: both masters hold requests, so each IDLE sees a new tie.
        s1_rw0 = 1'b1; s1_a0 = 16'h0010;
        s1_rw1 = 1'b1; s1_a1 = 16'h0020;
        s1_req0 = 1'b1; s1_req1 = 1'b1;
        c0 = cyc;
        q1.push_back('{1'b0, 16'h1234, c0 + 2});
        q1.push_back('{1'b1, 16'hBEEF, c0 + 5});
        q1.push_back('{1'b0, 16'h1234, c0 + 8});
        q1.push_back('{1'b1, 16'hBEEF, c0 + 11});
        for (int k = 0; k < 12; k++) begin
            @(negedge ck);
            if (k % 3 == 2) begin
                exp_own = (k % 6 == 5);
                chk("u1_owner_alt", {31'd0, s1_owner}, {31'd0, exp_own});
            end
            step();
        end
        s1_req0 = 1'b0; s1_req1 = 1'b0;
        step();

        // Latency 3 with the request dropped mid-access.
        s3_req0 = 1'b1; s3_rw0 = 1'b1; s3_a0 = 16'h0030;
        c0 = cyc;
        q3.push_back('{1'b0, 16'hA5A5, c0 + 4});
        for (int k = 0; k < 6; k++) begin
            @(negedge ck);
            chk("u3_busy", {31'd0, s3_busy}, {31'd0, (k >= 1 && k <= 4)});
            step();
            if (k == 1) s3_req0 = 1'b0;
        end

        // Reset during ACCESS aborts the read; master 1 then gets a clean access.
        s3_req0 = 1'b1; s3_rw0 = 1'b1; s3_a0 = 16'h0040;
        c0 = cyc;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s3_req0 = 1'b0;
        s3_req1 = 1'b1; s3_rw1 = 1'b1; s3_a1 = 16'h0030;
        q3.push_back('{1'b1, 16'hA5A5, c0 + 7});
        @(negedge ck);
        chk("u3_rst_idle", {29'd0, s3_busy, s3_mrw, s3_ack0}, {29'd0, 3'b010});
        chk("u3_rst_rd0", {16'd0, s3_rd0}, 32'd0);
        for (int k = 0; k < 5; k++) step();
        s3_req1 = 1'b0;
        for (int k = 0; k < 4; k++) step();

        chk("u1_queue_drained", q1.size(), 32'd0);
        chk("u3_queue_drained", q3.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
